// File: rtl/output_writeback_arbiter_if.sv
// Lane-FIFO and shared output-buffer write port bundle for the writeback arbiter.
// master: the arbiter (pops lane FIFOs, drives the buffer); slave: lane FIFOs plus buffer.
interface output_writeback_arbiter_if #(
  parameter int unsigned ARRAY_SIZE = 9,
  parameter int unsigned ADDR_W     = 14,
  parameter int unsigned DATA_W     = 16
);
  logic [ARRAY_SIZE-1:0]        is_empty;
  logic [ARRAY_SIZE*DATA_W-1:0] lane_data;
  logic [ARRAY_SIZE-1:0]        pop;
  logic                         mem_we;
  logic [ADDR_W-1:0]            mem_addr;
  logic [DATA_W-1:0]            mem_wdata;

  modport master (
    input  is_empty,
    input  lane_data,
    output pop,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );

  modport slave (
    output is_empty,
    output lane_data,
    input  pop,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );
endinterface

// File: rtl/output_writeback_arbiter.sv
// Round-robin writeback of per-lane FIFO streams into one shared output-buffer write port.
// Each lane writes fm*fm consecutive words from its latched base address, then raises done.
module output_writeback_arbiter #(
  parameter int unsigned ARRAY_SIZE = 9,
  parameter int unsigned ADDR_W     = 14,
  parameter int unsigned DIM_W      = 16,
  parameter int unsigned DATA_W     = 16
) (
  input  logic                         w_clk,
  input  logic                         reset,
  input  logic [ARRAY_SIZE-1:0]        start,
  input  logic [ARRAY_SIZE*ADDR_W-1:0] initial_address,
  input  logic [DIM_W-1:0]             output_featuremapsize,
  output logic [ARRAY_SIZE-1:0]        done,
  output logic                         all_done,
  output_writeback_arbiter_if.master   bus
);
  localparam int unsigned PtrW = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;
  localparam int unsigned CntW = 2 * DIM_W;

  typedef enum logic [1:0] {StIdle, StFill, StDone} state_e;

  state_e                state_q  [ARRAY_SIZE];
  logic [ADDR_W-1:0]     base_q   [ARRAY_SIZE];
  logic [CntW-1:0]       target_q [ARRAY_SIZE];
  logic [CntW-1:0]       count_q  [ARRAY_SIZE];
  logic [ARRAY_SIZE-1:0] done_q;
  logic [PtrW-1:0]       ptr_q;
  logic                  mem_we_q;
  logic [ADDR_W-1:0]     mem_addr_q;
  logic [DATA_W-1:0]     mem_wdata_q;

  logic [ADDR_W-1:0]     addr_in [ARRAY_SIZE];
  logic [DATA_W-1:0]     data_in [ARRAY_SIZE];
  logic [ARRAY_SIZE-1:0] req;
  logic [ARRAY_SIZE-1:0] grant;
  logic [PtrW-1:0]       grant_idx;
  logic [PtrW-1:0]       ptr_next;
  logic                  grant_vld;
  logic [PtrW:0]         idx;
  logic [CntW-1:0]       fm_sq;

  for (genvar g = 0; g < ARRAY_SIZE; g++) begin : g_unpack
    assign addr_in[g] = initial_address[g*ADDR_W +: ADDR_W];
    assign data_in[g] = bus.lane_data[g*DATA_W +: DATA_W];
  end

  assign fm_sq = CntW'(output_featuremapsize) * CntW'(output_featuremapsize);

  // Requests are masked during reset so pop never fires while state is being cleared.
  always_comb begin
    req = '0;
    for (int i = 0; i < ARRAY_SIZE; i++) begin
      req[i] = !reset && (state_q[i] == StFill) && !bus.is_empty[i];
    end
  end

  // First requester at or after ptr_q, wrapping; ptr_q already points past the last grant.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    idx       = '0;
    for (int k = 0; k < ARRAY_SIZE; k++) begin
      idx = {1'b0, ptr_q} + (PtrW+1)'(k);
      if (idx >= (PtrW+1)'(ARRAY_SIZE)) begin
        idx = idx - (PtrW+1)'(ARRAY_SIZE);
      end
      if (!grant_vld && req[idx[PtrW-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = idx[PtrW-1:0];
      end
    end
    if (grant_vld) begin
      grant[grant_idx] = 1'b1;
    end
  end

  assign ptr_next = (grant_idx == PtrW'(ARRAY_SIZE - 1)) ? '0 : grant_idx + PtrW'(1);

  always_ff @(posedge w_clk) begin
    if (reset) begin
      for (int i = 0; i < ARRAY_SIZE; i++) begin
        state_q[i]  <= StIdle;
        base_q[i]   <= '0;
        target_q[i] <= '0;
        count_q[i]  <= '0;
      end
      done_q      <= '0;
      ptr_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      mem_we_q <= grant_vld;
      if (grant_vld) begin
        mem_addr_q  <= base_q[grant_idx] + count_q[grant_idx][ADDR_W-1:0];
        mem_wdata_q <= data_in[grant_idx];
        ptr_q       <= ptr_next;
      end
      for (int i = 0; i < ARRAY_SIZE; i++) begin
        unique case (state_q[i])
          StIdle, StDone: begin
            if (start[i]) begin
              base_q[i]   <= addr_in[i];
              target_q[i] <= fm_sq;
              count_q[i]  <= '0;
              // An empty map finishes immediately without touching the buffer.
              if (fm_sq == '0) begin
                state_q[i] <= StDone;
                done_q[i]  <= 1'b1;
              end else begin
                state_q[i] <= StFill;
                done_q[i]  <= 1'b0;
              end
            end
          end
          StFill: begin
            if (grant[i]) begin
              count_q[i] <= count_q[i] + CntW'(1);
              if (count_q[i] + CntW'(1) == target_q[i]) begin
                state_q[i] <= StDone;
                done_q[i]  <= 1'b1;
              end
            end
          end
          default: state_q[i] <= StIdle;
        endcase
      end
    end
  end

  assign bus.pop       = grant;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign done          = done_q;
  assign all_done      = &done_q;

endmodule
